// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, synchronous flush and a
// saturating backpressure counter. It is reusable at ID/EX, EX/MEM and MEM/WB.
// The main entry drives the registered outputs. The skid entry holds the entry
// accepted while downstream stalls. in_ready is the only combinational output.
module pipe_stage_skid #(
  parameter int unsigned                DATA_W      = 128,
  parameter int unsigned                CTRL_W      = 6,
  parameter logic        [DATA_W-1:0]   BUBBLE_DATA = '0,
  parameter int unsigned                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q;
  logic                main_valid_q;
  logic                skid_valid_q;
  logic [1:0]          occupancy_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic in_fire;
  logic out_fire;

  // in_ready never looks at out_ready, which keeps the ready path registered.
  assign in_ready  = !skid_valid_q && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid_q && out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = occupancy_q;
  assign stall_cnt = stall_cnt_q;

  // Occupancy FSM. Outputs are loaded as registers on each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      occupancy_q  <= 2'd0;
      main_data_q  <= BUBBLE_DATA;
      main_ctrl_q  <= '0;
      skid_data_q  <= BUBBLE_DATA;
      skid_ctrl_q  <= '0;
    end else if (flush) begin
      // A same-cycle out_fire has already been taken downstream; drop everything.
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      occupancy_q  <= 2'd0;
      main_data_q  <= BUBBLE_DATA;
      main_ctrl_q  <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q      <= StOne;
            main_valid_q <= 1'b1;
            occupancy_q  <= 2'd1;
            main_data_q  <= in_data;
            main_ctrl_q  <= in_ctrl;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (in_fire) begin
            state_q      <= StFull;
            skid_valid_q <= 1'b1;
            occupancy_q  <= 2'd2;
            skid_data_q  <= in_data;
            skid_ctrl_q  <= in_ctrl;
          end else if (out_fire) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            occupancy_q  <= 2'd0;
            main_data_q  <= BUBBLE_DATA;
            main_ctrl_q  <= '0;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_q      <= StOne;
            skid_valid_q <= 1'b0;
            occupancy_q  <= 2'd1;
            main_data_q  <= skid_data_q;
            main_ctrl_q  <= skid_ctrl_q;
          end
        end
        default: begin
          state_q      <= StEmpty;
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          occupancy_q  <= 2'd0;
          main_data_q  <= BUBBLE_DATA;
          main_ctrl_q  <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with a valid entry held off by downstream.
  // Flush does not clear it; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. Inputs change 1 ns after the rising edge,
// and registered outputs are sampled there as well.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned CNT_W  = 4;
  localparam logic [DATA_W-1:0] BUBBLE = 16'hDEAD;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int pass_cnt;
  int total_cnt;

  pipe_stage_skid #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_DATA (BUBBLE),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== BUBBLE) $display("FAIL reset_out_data got %h want %h", out_data, BUBBLE); else pass_cnt++;
    total_cnt++; if (out_ctrl !== 6'd0) $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); else pass_cnt++;
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] v;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v = DATA_W'(i);
      offer(v, CTRL_W'(i));
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== v || out_ctrl !== CTRL_W'(i))
        $display("FAIL stream_%0d got v=%b d=%h c=%h want v=1 d=%h c=%h",
                 i, out_valid, out_data, out_ctrl, v, CTRL_W'(i));
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== BUBBLE)
      $display("FAIL stream_drain got v=%b d=%h want v=0 d=%h", out_valid, out_data, BUBBLE);
    else pass_cnt++;
    total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_skid_fill();
    out_ready = 1'b0;
    offer(16'h00A1, 6'h01);
    step();
    total_cnt++; if (in_ready !== 1'b1 || occupancy !== 2'd1)
      $display("FAIL skid_after_a got rdy=%b occ=%0d want rdy=1 occ=1", in_ready, occupancy);
    else pass_cnt++;
    offer(16'h00B2, 6'h02);
    step();
    offer(16'h00C3, 6'h03);
    #1;
    total_cnt++; if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 16'h00A1)
      $display("FAIL skid_full got rdy=%b occ=%0d d=%h want rdy=0 occ=2 d=00a1",
               in_ready, occupancy, out_data);
    else pass_cnt++;
    step();
    total_cnt++; if (in_ready !== 1'b0 || out_data !== 16'h00A1 || stall_cnt !== 4'd2)
      $display("FAIL skid_hold got rdy=%b d=%h cnt=%0d want rdy=0 d=00a1 cnt=2",
               in_ready, out_data, stall_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_data !== 16'h00B2 || out_ctrl !== 6'h02 || occupancy !== 2'd1 || in_ready !== 1'b1)
      $display("FAIL skid_drain_b got d=%h c=%h occ=%0d rdy=%b want d=00b2 c=02 occ=1 rdy=1",
               out_data, out_ctrl, occupancy, in_ready);
    else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h00C3)
      $display("FAIL skid_drain_c got v=%b d=%h want v=1 d=00c3", out_valid, out_data);
    else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd2)
      $display("FAIL skid_empty got v=%b occ=%0d cnt=%0d want v=0 occ=0 cnt=2",
               out_valid, occupancy, stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    offer(16'h00D4, 6'h04);
    step();
    offer(16'h00E5, 6'h05);
    step();
    offer(16'h00F6, 6'h06);
    flush = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || out_ctrl !== 6'd0 || out_data !== BUBBLE || occupancy !== 2'd0)
      $display("FAIL flush_full got v=%b c=%h d=%h occ=%0d want v=0 c=00 d=%h occ=0",
               out_valid, out_ctrl, out_data, occupancy, BUBBLE);
    else pass_cnt++;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (out_valid !== 1'b0)
        $display("FAIL flush_no_leak_%0d got v=%b d=%h want v=0", i, out_valid, out_data);
      else pass_cnt++;
    end
    total_cnt++; if (stall_cnt !== 4'd4) $display("FAIL flush_stall_cnt got %0d want 4", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_flush_fire();
    out_ready = 1'b1;
    offer(16'h0107, 6'h07);
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL flush_fire got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    else pass_cnt++;
    flush = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== BUBBLE)
      $display("FAIL flush_fire_dup got v=%b d=%h want v=0 d=%h", out_valid, out_data, BUBBLE);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    offer(16'h0208, 6'h08);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_reach got %0d want 15", stall_cnt); else pass_cnt++;
    step();
    total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d want 15", stall_cnt); else pass_cnt++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_flush got %0d want 15", stall_cnt); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL sat_reset got %0d want 0", stall_cnt); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(16'h0309, 6'h09);
    step();
    offer(16'h040A, 6'h0A);
    step();
    in_valid = 1'b0;
    total_cnt++; if (occupancy !== 2'd2) $display("FAIL async_pre_full got %0d want 2", occupancy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
                     out_data !== BUBBLE || out_ctrl !== 6'd0 || stall_cnt !== 4'd0)
      $display("FAIL async_reset got v=%b occ=%0d rdy=%b d=%h c=%h cnt=%0d want v=0 occ=0 rdy=1 d=%h c=00 cnt=0",
               out_valid, occupancy, in_ready, out_data, out_ctrl, stall_cnt, BUBBLE);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush_full();
    test_flush_fire();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
